// File: rtl/crossing_period_meter.sv
// -----------------------------------------------------------------------------
// crossing_period_meter
//
// Measures the mean period of a signal from interpolated crossing events.
// Every accepted crossing is timestamped as {sample_cnt, t}: a free-running
// integer sample counter with the 8-bit fractional crossing offset appended.
// Over a window of 2^AVG_LOG2 consecutive periods the span between the window's
// first and last timestamp is divided by the period count (logical right shift,
// truncating). The result is an unsigned fixed-point period with 8 fractional
// bits. Windows run back to back: the crossing that closes one window opens the
// next.
//
// Optional feature (compile-time macro CROSSING_PERIOD_MEASURE_GLITCH_REJECT_EN):
//   when defined, a crossing arriving fewer than min_gap cycles after the last
//   accepted crossing is ignored. This suppresses noise-induced multiple
//   crossings. When undefined, every t_valid in ARM/MEAS is accepted and
//   min_gap is ignored.
//
// Parameters
//   CNT_W     width of the integer sample counter (longest window 2^CNT_W-1)
//   AVG_LOG2  a window covers 2^AVG_LOG2 periods, legal range 0..8
//
// Ports
//   clk           sample clock, one ADC sample per cycle
//   reset         synchronous, active-high
//   run           measurement enable; low forces IDLE on the next cycle
//   t             fractional crossing offset, units of 1/256 sample
//   t_valid       single-cycle strobe qualifying t
//   min_gap       minimum spacing of accepted crossings (glitch-reject builds)
//   period        mean period, CNT_W integer bits + 8 fractional bits
//   period_valid  one-cycle strobe qualifying period
//   timeout       one-cycle strobe when a window runs out of counter range
// -----------------------------------------------------------------------------
module crossing_period_meter #(
  parameter int CNT_W    = 24,
  parameter int AVG_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [7:0]         t,
  input  logic               t_valid,
  input  logic [CNT_W-1:0]   min_gap,
  output logic [CNT_W+7:0]   period,
  output logic               period_valid,
  output logic               timeout
);

  localparam int TS_W = CNT_W + 8;
  // n_cnt must be able to hold 2^AVG_LOG2 itself, hence one extra bit.
  localparam int N_W = AVG_LOG2 + 1;
  localparam logic [N_W-1:0]   WIN_N   = N_W'(1) << AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS
  } state_t;

  // Mean period over one window: modular span of the timestamps divided by
  // the number of periods, truncating. The span cannot alias because a window
  // is abandoned before it reaches 2^CNT_W samples.
  function automatic logic [TS_W-1:0] span_mean(input logic [TS_W-1:0] ts_now,
                                                input logic [TS_W-1:0] ts_old);
    logic [TS_W-1:0] span;
    span = ts_now - ts_old;
    return span >> AVG_LOG2;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [N_W-1:0]   n_cnt;
  logic [N_W-1:0]   n_next;
  logic [TS_W-1:0]  ts_ref;

  logic [TS_W-1:0]  ts_p0;
  logic             gap_ok;
  logic             win_full;
  logic             accept;
  logic             win_close;
  logic             ref_load;

  logic [TS_W-1:0]  period_p1;
  logic             vld_p1;
  logic             tmo_p1;

`ifdef CROSSING_PERIOD_MEASURE_GLITCH_REJECT_EN
  logic [CNT_W-1:0] gap_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  assign gap_ok = (gap_cnt >= min_gap);

  // gap_cnt is cycles since the last accepted crossing. Outside a measurement
  // it rests saturated so the first crossing after arming is never rejected.
  always_ff @(posedge clk) begin
    if (reset || (state == S_IDLE)) begin
      gap_cnt <= CNT_MAX;
    end else if (accept) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= sat_inc(gap_cnt);
    end
  end
`else
  logic unused_min_gap;

  assign unused_min_gap = ^min_gap;
  assign gap_ok         = 1'b1;
`endif

  // ---- stage p0: timestamp and acceptance decode ----
  assign ts_p0    = {sample_cnt, t};
  assign n_next   = n_cnt + 1'b1;
  // win_cnt lags the true cycle count by one, so hitting CNT_MAX here means
  // the window has lasted 2^CNT_W cycles: a crossing now would alias.
  assign win_full = (state == S_MEAS) && (win_cnt == CNT_MAX);
  // A timeout in the same cycle as a crossing discards the crossing.
  assign accept   = run && t_valid && gap_ok &&
                    ((state == S_ARM) || ((state == S_MEAS) && !win_full));
  assign win_close = accept && (state == S_MEAS) && (n_next == WIN_N);
  assign ref_load  = (accept && (state == S_ARM)) || win_close;

  // Reference timestamp is pure data; its value only matters once loaded.
  always_ff @(posedge clk) begin
    if (ref_load) begin
      ts_ref <= ts_p0;
    end
  end

  // Control state, counters and the registered result stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      n_cnt      <= '0;
      win_cnt    <= '0;
      period_p1  <= '0;
      vld_p1     <= 1'b0;
      tmo_p1     <= 1'b0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
      vld_p1     <= 1'b0;
      tmo_p1     <= 1'b0;

      if (!run) begin
        // Partial windows are dropped silently.
        state   <= S_IDLE;
        n_cnt   <= '0;
        win_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_ARM;
            n_cnt   <= '0;
            win_cnt <= '0;
          end

          S_ARM: begin
            if (accept) begin
              state   <= S_MEAS;
              n_cnt   <= '0;
              win_cnt <= '0;
            end
          end

          S_MEAS: begin
            if (win_full) begin
              tmo_p1  <= 1'b1;
              state   <= S_ARM;
              n_cnt   <= '0;
              win_cnt <= '0;
            end else if (win_close) begin
              // ---- stage p1: subtract, shift, register ----
              period_p1 <= span_mean(ts_p0, ts_ref);
              vld_p1    <= 1'b1;
              n_cnt     <= '0;
              win_cnt   <= '0;
            end else begin
              if (accept) begin
                n_cnt <= n_next;
              end
              win_cnt <= win_cnt + 1'b1;
            end
          end

          default: begin
            state   <= S_IDLE;
            n_cnt   <= '0;
            win_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign period       = period_p1;
  assign period_valid = vld_p1;
  assign timeout      = tmo_p1;

endmodule

// File: tb/tb_crossing_period_meter.sv
module tb_crossing_period_meter;

  localparam int     CNT_W    = 12;
  localparam int     AVG_LOG2 = 2;
  localparam int     PW       = CNT_W + 8;
  localparam longint WIN_N    = longint'(1) << AVG_LOG2;
  localparam longint CNT_SPAN = longint'(1) << CNT_W;
  localparam longint GAP_MAX  = CNT_SPAN - 1;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MEAS = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [7:0]       t;
  logic             t_valid;
  logic [CNT_W-1:0] min_gap;
  logic [PW-1:0]    period;
  logic             period_valid;
  logic             timeout;

  always #5 clk = ~clk;

  crossing_period_meter #(
    .CNT_W   (CNT_W),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .t           (t),
    .t_valid     (t_valid),
    .min_gap     (min_gap),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout)
  );

  int checks   = 0;
  int failures = 0;

  // k = absolute cycle index (cycles since reset release) of the next step.
  longint k;

  // Reference model: absolute, unbounded time; windows tracked by crossing
  // count and the absolute cycle of the reference crossing.
  int            m_mode;
  longint        m_ref_abs;
  longint        m_ref_k;
  longint        m_last_k;
  bit            m_have_last;
  int            m_n;
  logic          m_pv;
  logic          m_to;
  logic [PW-1:0] m_period;

  int            pv_seen;
  int            to_seen;
  bit            chk_en;
  logic [PW-1:0] chk_period;

  typedef struct {
    int            interval;
    int            n_cross;
    int            t0;
    int            tmode;     // 0 constant, 1 alternate 0x00/0x80, 2 step +1
    logic [PW-1:0] exp_period;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_cycle();
    longint abs_ts;
    bit     ok;
`ifdef CROSSING_PERIOD_MEASURE_GLITCH_REJECT_EN
    longint gap;
    gap = m_have_last ? (k - m_last_k - 1) : GAP_MAX;
    if (gap > GAP_MAX) gap = GAP_MAX;
    ok = t_valid && (gap >= longint'(min_gap));
`else
    ok = t_valid;
`endif
    abs_ts = k * 256 + longint'(t);
    m_pv = 1'b0;
    m_to = 1'b0;
    if (!run) begin
      m_mode      = M_IDLE;
      m_have_last = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_mode      = M_ARM;
      m_have_last = 1'b0;
    end else if ((m_mode == M_MEAS) && (k - m_ref_k == CNT_SPAN)) begin
      m_to   = 1'b1;
      m_mode = M_ARM;
    end else if (ok) begin
      m_have_last = 1'b1;
      m_last_k    = k;
      if (m_mode == M_ARM) begin
        m_ref_abs = abs_ts;
        m_ref_k   = k;
        m_n       = 0;
        m_mode    = M_MEAS;
      end else begin
        m_n++;
        if (m_n == WIN_N) begin
          m_pv      = 1'b1;
          m_period  = PW'((abs_ts - m_ref_abs) >> AVG_LOG2);
          m_ref_abs = abs_ts;
          m_ref_k   = k;
          m_n       = 0;
        end
      end
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    check($sformatf("cycle%0d", k), {period_valid, timeout, period}, {m_pv, m_to, m_period});
    if (period_valid) begin
      pv_seen++;
      if (chk_en) check("window_period", period, chk_period);
    end
    if (timeout) to_seen++;
    k++;
  endtask

  function automatic logic [7:0] tval(input int tmode, input int t0, input int i);
    case (tmode)
      1:       return (i % 2 == 1) ? 8'h80 : 8'h00;
      2:       return 8'(t0 + i);
      default: return 8'(t0);
    endcase
  endfunction

  task automatic train(input int interval, input int n, input int t0, input int tmode,
                       input bit toggle);
    if (toggle) begin
      run = 1'b0;
      step();
      run = 1'b1;
      step();
    end
    for (int i = 0; i < n; i++) begin
      t_valid = 1'b1;
      t       = tval(tmode, t0, i);
      step();
      t_valid = 1'b0;
      for (int j = 1; j < interval; j++) step();
    end
    step();
    step();
  endtask

  initial begin
    longint k0;

    vecs[0] = '{100,  13, 8'h40, 0, 20'h06400};
    vecs[1] = '{100,  13, 0,     1, 20'h06400};
    vecs[2] = '{100,  13, 0,     2, 20'h06401};
    vecs[3] = '{37,   13, 8'hFF, 0, 20'h02500};
    vecs[4] = '{1,    13, 8'h20, 0, 20'h00100};
    vecs[5] = '{1000, 9,  8'h40, 0, 20'h3E800};

    reset   = 1'b1;
    run     = 1'b0;
    t_valid = 1'b0;
    t       = 8'h00;
    min_gap = '0;

    m_mode      = M_IDLE;
    m_ref_abs   = 0;
    m_ref_k     = 0;
    m_last_k    = 0;
    m_have_last = 1'b0;
    m_n         = 0;
    m_pv        = 1'b0;
    m_to        = 1'b0;
    m_period    = '0;
    pv_seen     = 0;
    to_seen     = 0;
    chk_en      = 1'b0;
    chk_period  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_period", period, 0);
    check("reset_period_valid", period_valid, 0);
    check("reset_timeout", timeout, 0);
    reset = 1'b0;
    k     = 0;
    run   = 1'b1;

    // Steady trains with known mean periods.
    for (int i = 0; i < 6; i++) begin
      pv_seen    = 0;
      to_seen    = 0;
      chk_en     = 1'b1;
      chk_period = vecs[i].exp_period;
      train(vecs[i].interval, vecs[i].n_cross, vecs[i].t0, vecs[i].tmode, 1'b1);
      chk_en = 1'b0;
      check($sformatf("vec%0d_windows", i), pv_seen, (vecs[i].n_cross - 1) / WIN_N);
      check($sformatf("vec%0d_no_timeout", i), to_seen, 0);
    end

    // Window spanning the sample counter wrap.
    run = 1'b0;
    step();
    run = 1'b1;
    while ((k % CNT_SPAN) != CNT_SPAN - 16) step();
    pv_seen    = 0;
    to_seen    = 0;
    chk_en     = 1'b1;
    chk_period = 20'h06400;
    train(100, 5, 8'h40, 0, 1'b0);
    chk_en = 1'b0;
    check("wrap_windows", pv_seen, 1);
    check("wrap_no_timeout", to_seen, 0);

    // Timeout: one crossing then silence; a crossing coinciding with the
    // timeout is discarded; afterwards a fresh window measures correctly.
    run = 1'b0;
    step();
    run = 1'b1;
    step();
    pv_seen = 0;
    to_seen = 0;
    t_valid = 1'b1;
    t       = 8'h40;
    step();
    t_valid = 1'b0;
    k0      = k - 1;
    while (k < k0 + CNT_SPAN) step();
    t_valid = 1'b1;
    t       = 8'h10;
    step();
    t_valid = 1'b0;
    step();
    check("timeout_count", to_seen, 1);
    check("timeout_no_period", pv_seen, 0);
    chk_en     = 1'b1;
    chk_period = 20'h06400;
    train(100, 5, 8'h40, 0, 1'b0);
    chk_en = 1'b0;
    check("after_timeout_windows", pv_seen, 1);
    check("after_timeout_count", to_seen, 1);

    // run dropped for one cycle after the 3rd crossing of a window.
    pv_seen    = 0;
    to_seen    = 0;
    chk_en     = 1'b1;
    chk_period = 20'h06400;
    run = 1'b0;
    step();
    run = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      t_valid = 1'b1;
      t       = 8'h40;
      step();
      t_valid = 1'b0;
      for (int j = 1; j < 100; j++) begin
        run = !((i == 2) && (j == 50));
        step();
      end
      run = 1'b1;
    end
    step();
    step();
    chk_en = 1'b0;
    check("run_drop_windows", pv_seen, 1);

    // Extra crossing 10 cycles after each real one, min_gap = 50.
    min_gap = CNT_W'(50);
    pv_seen = 0;
`ifdef CROSSING_PERIOD_MEASURE_GLITCH_REJECT_EN
    chk_en     = 1'b1;
    chk_period = 20'h06400;
`endif
    run = 1'b0;
    step();
    run = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      t_valid = 1'b1;
      t       = 8'h40;
      step();
      t_valid = 1'b0;
      for (int j = 1; j < 100; j++) begin
        t_valid = (j == 10);
        t       = (j == 10) ? 8'h99 : 8'h40;
        step();
      end
      t_valid = 1'b0;
    end
    step();
    step();
    chk_en = 1'b0;
`ifdef CROSSING_PERIOD_MEASURE_GLITCH_REJECT_EN
    check("glitch_windows", pv_seen, 2);
`endif
    min_gap = '0;

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) min_gap = CNT_W'($urandom_range(0, 8));
      run     = ($urandom_range(0, 299) != 0);
      t_valid = ($urandom_range(0, 3) == 0);
      t       = 8'($urandom);
      step();
    end
    run     = 1'b1;
    t_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crossing_period_meter.md
# crossing_period_meter

Measures signal period from interpolated crossing events. It sits directly downstream of the crossing interpolator and consumes its 8-bit fractional crossing time `t` and `t_valid` strobe. Each accepted crossing is timestamped with a free-running sample counter. The block reports the mean period over 2^AVG_LOG2 consecutive crossings as an unsigned fixed-point value with 8 fractional bits, for use by frequency readout and tuning logic.

## Interface
- `CNT_W`, 24: width of the integer sample counter; the longest measurable window is 2^CNT_W-1 samples.
- `AVG_LOG2`, 4: a window covers 2^AVG_LOG2 periods. Legal range is 0..8.

- `clk` in 1: sample clock; one ADC sample per cycle.
- `reset` in 1: synchronous, active-high.
- `run` in 1: measurement enable. Low forces IDLE.
- `t` in 8: fractional crossing offset from the earlier sample, in units of 1/256 sample.
- `t_valid` in 1: single-cycle strobe qualifying `t`.
- `min_gap` in CNT_W: minimum spacing between accepted crossings, in samples. Used only with the glitch-reject macro.
- `period` out CNT_W+8: mean period in samples, with 8 fractional bits.
- `period_valid` out 1: one-cycle strobe qualifying `period`.
- `timeout` out 1: one-cycle strobe when a window exceeds 2^CNT_W-1 samples.

## Operation
- `sample_cnt` (CNT_W bits) increments every cycle after reset and wraps modulo 2^CNT_W.
- Timestamp: `ts = {sample_cnt, t}` (CNT_W+8 bits), captured in the cycle `t_valid` is high.
  - The fixed upstream latency adds a constant offset to every timestamp. The offset cancels in differences and is not compensated.
- An accepted crossing is a `t_valid` cycle, in ARM or MEAS, that passes glitch rejection (see Configuration).
- States:
  - IDLE: entered on reset or when `run`=0. All counters except `sample_cnt` are cleared. When `run`=1, next state is ARM.
  - ARM: the first accepted crossing stores `ts_ref`=ts, clears `n_cnt` and `win_cnt`, and moves to MEAS.
  - MEAS: each accepted crossing increments `n_cnt`.
    - When `n_cnt` reaches 2^AVG_LOG2: `period` = (ts - ts_ref) mod 2^(CNT_W+8), shifted right logically by AVG_LOG2 (truncating); `period_valid` pulses.
    - On that same crossing, `ts_ref`=ts, `n_cnt`=0, `win_cnt`=0, and the state stays MEAS. Windows are back-to-back and no crossing is lost.
- `win_cnt` counts cycles in MEAS since `ts_ref` was set.
  - Reaching 2^CNT_W-1 pulses `timeout`, discards the window, and returns to ARM.
  - Because of this, the subtraction never aliases when `sample_cnt` wraps.
- If a timeout and an accepted crossing occur in the same cycle, the timeout wins and the crossing is discarded.
- `run` falling mid-window: IDLE on the next cycle. No `period_valid` or `timeout` is issued for the partial window.
- `t_valid` in IDLE is ignored.
- `period` holds its last value between strobes.

## Timing
- Reset values: `period`=0, `period_valid`=0, `timeout`=0, state=IDLE, `sample_cnt`=0, `n_cnt`=0, `win_cnt`=0, `gap_cnt` saturated at 2^CNT_W-1.
- `period_valid` rises exactly 1 cycle after the `t_valid` cycle that closes a window.
- `timeout` rises 1 cycle after `win_cnt` reaches its limit.
- The block accepts back-to-back `t_valid` (every cycle) with no stalls. There is no backpressure.
- The subtract and shift fit in one register stage. `period` and `period_valid` are registered outputs.

## Configuration
- `CROSSING_PERIOD_MEASURE_GLITCH_REJECT_EN`
  - Defined: `gap_cnt` (CNT_W bits, saturating) counts cycles since the last accepted crossing, and is reset to 0 on each accepted crossing.
    - A `t_valid` with `gap_cnt` < `min_gap` is ignored: no timestamp, no count. This suppresses noise-induced multiple crossings.
    - `min_gap`=0 accepts all crossings.
  - Undefined: every `t_valid` in ARM/MEAS is accepted. `min_gap` is unused and `gap_cnt` is not synthesised.

## Test plan
- CNT_W=16, AVG_LOG2=2, `run`=1, `t_valid` every 100 cycles with t=0x40 -> first `period_valid` after the 5th crossing, 1 cycle late, `period`=0x006400, repeating every 400 cycles.
- Same setup, t alternating 0x00/0x80 -> each window's span comprises two +0x80 and two −0x80 fractional offsets, so the offsets cancel and `period`=0x006400. Repeat with t stepping +1 per crossing -> `period`=0x006401.
- Start crossings with `sample_cnt` near 0xFFF0 so the window spans the counter wrap -> `period` is correct (0x006400) with no timeout.
- One crossing, then none for 65535 cycles -> `timeout` pulses once, state returns to ARM, and no `period_valid` follows; the next two crossings 100 apart begin a fresh window.
- Drop `run` for 1 cycle after the 3rd crossing of a window -> no `period_valid` for that window; re-arm on the next crossing and get a correct period afterwards.
- With the macro, `min_gap`=50 and an extra `t_valid` 10 cycles after each real crossing -> extras ignored, `period`=0x006400. Without the macro, the same stimulus shifts the window boundaries; check against the model.
